// File: rtl/mux_rr_pkg.sv
// Shared types and helpers for the round-robin lane multiplexer.
// Holds the one-hot FSM encoding and the rotating priority search.
package mux_rr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        TRANS = 2'b10
    } state_t;

    localparam int RR_MAXCH = 16;
    localparam int STAT_W   = 16;

    // First set bit of valid, searching last+1, last+2, ... mod nch.
    // Walk from the farthest offset down so the nearest hit wins.
    function automatic int rr_pick(
        input logic [RR_MAXCH-1:0] valid,
        input int                  last,
        input int                  nch
    );
        int idx;
        int res;
        res = 0;
        for (int i = RR_MAXCH; i >= 1; i--) begin
            if (i <= nch) begin
                idx = (last + i) % nch;
                if (valid[idx[3:0]])
                    res = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_arb_rr_picker.sv
// Combinational round-robin picker: rotates priority to start at last+1.
// Ports: i_valid (request vector), i_last (previous owner), o_found, o_idx.
module rr_picker
    import mux_rr_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] i_valid,
    input  logic [CHW-1:0] i_last,
    output logic           o_found,
    output logic [CHW-1:0] o_idx
);

    logic [RR_MAXCH-1:0] w_valid;

    always_comb begin
        w_valid          = '0;
        w_valid[NCH-1:0] = i_valid;
    end

    assign o_found = |i_valid;
    assign o_idx   = CHW'(rr_pick(w_valid, int'(i_last), NCH));

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel lane mux with round-robin arbitration, burst lock and valid/ready.
// Ports: clk8f, reset (sync, active-low), data_in/valid_in/ready_in upstream,
//   data_out/valid_out/chan_out/ready_out downstream,
//   xfer_cnt per-channel word counters only when MUX_RR_STATS_EN is defined.
module mux_rr_arb
    import mux_rr_pkg::*;
#(
    parameter  int NCH      = 4,
    parameter  int DW       = 8,
    parameter  int MAXBURST = 0,
    localparam int CHW      = $clog2(NCH)
) (
    input  logic                clk8f,
    input  logic                reset,
    input  logic [NCH*DW-1:0]   data_in,
    input  logic [NCH-1:0]      valid_in,
    output logic [NCH-1:0]      ready_in,
    output logic [DW-1:0]       data_out,
    output logic                valid_out,
    output logic [CHW-1:0]      chan_out,
    input  logic                ready_out
`ifdef MUX_RR_STATS_EN
    ,
    output logic [NCH*16-1:0]   xfer_cnt
`endif
);

    localparam logic [15:0] MB = 16'(MAXBURST);

    state_t         r_state, w_state_n;
    logic [CHW-1:0] r_owner, w_owner_n;
    logic [CHW-1:0] r_last,  w_last_n;
    logic [15:0]    r_cnt,   w_cnt_n;
    logic [DW-1:0]  r_data;
    logic           r_valid;
    logic [CHW-1:0] r_chan;

    logic           w_can_load;
    logic           w_found;
    logic [CHW-1:0] w_pick;
    logic [NCH-1:0] w_others;
    logic           w_cont;
    logic           w_acc;
    logic [CHW-1:0] w_sel;
    logic [NCH-1:0] w_ready;
    logic [DW-1:0]  w_word;

    rr_picker #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_pick (
        .i_valid (valid_in),
        .i_last  (r_last),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_can_load = !r_valid || ready_out;

    always_comb begin
        w_others          = valid_in;
        w_others[r_owner] = 1'b0;
    end

    // Past the burst limit the owner may keep going only if nobody else waits.
    assign w_cont = valid_in[r_owner] &&
                    ((MAXBURST == 0) || (r_cnt < MB) || !(|w_others));

    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_last_n  = r_last;
        w_cnt_n   = r_cnt;
        w_acc     = 1'b0;
        w_sel     = r_owner;
        w_ready   = '0;
        case (r_state)
            IDLE: begin
                if (w_found && w_can_load) begin
                    w_sel     = w_pick;
                    w_acc     = 1'b1;
                    w_owner_n = w_pick;
                    w_state_n = TRANS;
                    w_cnt_n   = 16'd1;
                end
            end
            TRANS: begin
                if (w_can_load) begin
                    if (w_cont) begin
                        w_acc   = 1'b1;
                        w_cnt_n = (MAXBURST != 0 && r_cnt >= MB) ?
                                  16'd1 : r_cnt + 16'd1;
                    end else begin
                        // Release costs one bubble; owner becomes lowest priority.
                        w_last_n  = r_owner;
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (w_acc)
            w_ready[w_sel] = 1'b1;
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NCH; i++)
            if (w_sel == CHW'(i))
                w_word = data_in[i*DW +: DW];
    end

    assign ready_in = w_ready;

    always_ff @(posedge clk8f) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= CHW'(NCH - 1);
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_last  <= w_last_n;
            r_cnt   <= w_cnt_n;
            if (w_can_load) begin
                r_valid <= w_acc;
                if (w_acc) begin
                    r_data <= w_word;
                    r_chan <= w_sel;
                end
            end
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign chan_out  = r_chan;

`ifdef MUX_RR_STATS_EN
    for (genvar g = 0; g < NCH; g++) begin : g_stat
        logic [STAT_W-1:0] r_xfer;
        always_ff @(posedge clk8f) begin
            if (!reset)
                r_xfer <= '0;
            else if (w_ready[g] && valid_in[g] && r_xfer != '1)
                r_xfer <= r_xfer + 16'd1;
        end
        assign xfer_cnt[g*STAT_W +: STAT_W] = r_xfer;
    end
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: directed traffic, per-cycle expectations.
// Two instances: MAXBURST=0 (u_dut0) and MAXBURST=2 (u_dut1).
module tb_mux_rr_arb;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CHW = 2;

    logic              clk8f = 1'b0;
    logic              reset = 1'b0;
    logic [NCH*DW-1:0] data_in = '0;
    logic [NCH-1:0]    valid_in = '0;
    logic              ready_out = 1'b1;

    logic [NCH-1:0]    rdy0, rdy1;
    logic [DW-1:0]     dout0, dout1;
    logic              vout0, vout1;
    logic [CHW-1:0]    cout0, cout1;
`ifdef MUX_RR_STATS_EN
    logic [NCH*16-1:0] xc0, xc1;
`endif

    always #5 clk8f = ~clk8f;

    mux_rr_arb #(.NCH(NCH), .DW(DW), .MAXBURST(0)) u_dut0 (
        .clk8f     (clk8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (rdy0),
        .data_out  (dout0),
        .valid_out (vout0),
        .chan_out  (cout0),
        .ready_out (ready_out)
`ifdef MUX_RR_STATS_EN
        ,
        .xfer_cnt  (xc0)
`endif
    );

    mux_rr_arb #(.NCH(NCH), .DW(DW), .MAXBURST(2)) u_dut1 (
        .clk8f     (clk8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_in  (rdy1),
        .data_out  (dout1),
        .valid_out (vout1),
        .chan_out  (cout1),
        .ready_out (ready_out)
`ifdef MUX_RR_STATS_EN
        ,
        .xfer_cnt  (xc1)
`endif
    );

    typedef struct {
        logic       v;
        int         ch;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] src_q[NCH][$];
    int         n_chk = 0;
    int         n_err = 0;
    bit         sel = 1'b0;
    bit         no_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wd(input int ch, input int s);
        return 8'(ch * 16 + s);
    endfunction

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            valid_in[c] = src_q[c].size() > 0;
            data_in[c*DW +: DW] = (src_q[c].size() > 0) ? src_q[c][0] : 8'h00;
        end
    endtask

    task automatic push(input logic v, input int ch, input logic [7:0] d);
        exp_t e;
        e.v  = v;
        e.ch = ch;
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        logic [NCH-1:0] rdy, hs;
        exp_t           e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk8f);
            rdy = sel ? rdy1 : rdy0;
            check("onehot", 32'($onehot0(rdy)), 32'd1);
            if (no_rdy)
                check("stall_rdy", 32'(rdy), 32'd0);
            hs = reset ? (valid_in & rdy) : '0;
            @(posedge clk8f);
            #1;
            for (int k = 0; k < NCH; k++)
                if (hs[k])
                    void'(src_q[k].pop_front());
            drive();
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("valid", 32'(sel ? vout1 : vout0), 32'(e.v));
                if (e.v) begin
                    check("chan", 32'(sel ? cout1 : cout0), 32'(e.ch));
                    check("data", 32'(sel ? dout1 : dout0), 32'(e.d));
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int c = 0; c < NCH; c++)
            src_q[c].delete();
        sb.delete();
        drive();
        @(posedge clk8f);
        #1;
        check("rst_valid", 32'(sel ? vout1 : vout0), 32'd0);
        check("rst_data",  32'(sel ? dout1 : dout0), 32'd0);
        check("rst_chan",  32'(sel ? cout1 : cout0), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        // Single channel 2, back-to-back, no bubbles.
        sel = 1'b0;
        do_reset();
        src_q[2].push_back(8'hA5);
        src_q[2].push_back(8'h5A);
        drive();
        push(1'b1, 2, 8'hA5);
        push(1'b1, 2, 8'h5A);
        push(1'b0, 0, 8'h00);
        run(3);

        // All valid, unlimited burst, ch0 drops after 3 words.
        do_reset();
        for (int s = 0; s < 3; s++) src_q[0].push_back(wd(0, s));
        for (int c = 1; c < NCH; c++)
            for (int s = 0; s < 8; s++) src_q[c].push_back(wd(c, s));
        drive();
        for (int s = 0; s < 3; s++) push(1'b1, 0, wd(0, s));
        push(1'b0, 0, 8'h00);
        push(1'b1, 1, wd(1, 0));
        push(1'b1, 1, wd(1, 1));
        run(6);

        // Burst limit 2 with all channels valid.
        sel = 1'b1;
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 10; s++) src_q[c].push_back(wd(c, s));
        drive();
        for (int c = 0; c < NCH; c++) begin
            push(1'b1, c, wd(c, 0));
            push(1'b1, c, wd(c, 1));
            push(1'b0, 0, 8'h00);
        end
        push(1'b1, 0, wd(0, 2));
        run(13);

        // Downstream stall mid-burst.
        sel = 1'b0;
        do_reset();
        for (int s = 0; s < 8; s++) src_q[1].push_back(wd(1, s));
        drive();
        push(1'b1, 1, wd(1, 0));
        push(1'b1, 1, wd(1, 1));
        run(2);
        ready_out = 1'b0;
        no_rdy = 1'b1;
        repeat (5) push(1'b1, 1, wd(1, 1));
        run(5);
        no_rdy = 1'b0;
        ready_out = 1'b1;
        push(1'b1, 1, wd(1, 2));
        push(1'b1, 1, wd(1, 3));
        run(2);

        // Reset mid-burst on ch3, then ch0 wins first.
        do_reset();
        for (int s = 0; s < 8; s++) src_q[3].push_back(wd(3, s));
        drive();
        push(1'b1, 3, wd(3, 0));
        push(1'b1, 3, wd(3, 1));
        run(2);
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < 4; s++) src_q[c].push_back(wd(c, s));
        drive();
        push(1'b1, 0, wd(0, 0));
        push(1'b1, 0, wd(0, 1));
        run(2);

`ifdef MUX_RR_STATS_EN
        // Saturating counter on ch1.
        do_reset();
        for (int s = 0; s < 70000; s++) src_q[1].push_back(8'(s));
        drive();
        run(70002);
        check("xfer_ch0", 32'(xc0[0  +: 16]), 32'd0);
        check("xfer_ch1", 32'(xc0[16 +: 16]), 32'hFFFF);
        check("xfer_ch2", 32'(xc0[32 +: 16]), 32'd0);
        check("xfer_ch3", 32'(xc0[48 +: 16]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
